// File: rtl/tape_player.sv
// Virtual cassette player: synthesises the Apple-1 ACI tape waveform (header tone, sync, bit cycles) from a byte stream.
// Build option: define TAPE_PLAYER_PASSTHRU_EN to route tape_in_ext to tape_in while idle.
module tape_player #(
  parameter int HDR_HALF    = 37190,
  parameter int HDR_CYCLES  = 3850,
  parameter int SYNC_A_HALF = 11455,
  parameter int SYNC_B_HALF = 14318,
  parameter int ONE_HALF    = 28636,
  parameter int ZERO_HALF   = 14318
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  input  logic       tape_in_ext,
  output logic       tape_in,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_SYNC_A = 3'd2,
    S_SYNC_B = 3'd3,
    S_LOAD   = 3'd4,
    S_BIT_H1 = 3'd5,
    S_BIT_H2 = 3'd6,
    S_FINISH = 3'd7
  } state_t;

  localparam logic [15:0] HDR_RELOAD    = 16'(HDR_HALF - 1);
  localparam logic [15:0] SYNC_A_RELOAD = 16'(SYNC_A_HALF - 1);
  localparam logic [15:0] SYNC_B_RELOAD = 16'(SYNC_B_HALF - 1);
  localparam logic [15:0] HDR_LAST      = 16'(2 * HDR_CYCLES - 1);

  // Counter reload value for one half of a data bit.
  function automatic logic [15:0] bit_half(input logic b);
    if (b) begin
      return 16'(ONE_HALF - 1);
    end else begin
      return 16'(ZERO_HALF - 1);
    end
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hdr_q, hdr_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        last_q, last_d;
  logic        level_q, level_d;
  logic        underrun_q, underrun_d;
  logic        tape_q, tape_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        expire_s;
  logic        accept_s;
  logic        idle_level_s;

  assign expire_s = (cnt_q == 16'd0);
  assign accept_s = (state_q == S_LOAD) && byte_valid && ready_q;

`ifdef TAPE_PLAYER_PASSTHRU_EN
  assign idle_level_s = tape_in_ext;
`else
  logic unused_ext_s;
  assign unused_ext_s = tape_in_ext;
  assign idle_level_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop overrides everything, including a coincident start.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = start ? S_HEADER : S_IDLE;
        S_HEADER: state_d = (expire_s && (hdr_q == HDR_LAST)) ? S_SYNC_A : S_HEADER;
        S_SYNC_A: state_d = expire_s ? S_SYNC_B : S_SYNC_A;
        S_SYNC_B: state_d = expire_s ? S_LOAD : S_SYNC_B;
        S_LOAD:   state_d = accept_s ? S_BIT_H1 : S_LOAD;
        S_BIT_H1: state_d = expire_s ? S_BIT_H2 : S_BIT_H1;
        S_BIT_H2: begin
          if (!expire_s) begin
            state_d = S_BIT_H2;
          end else if (bitcnt_q != 3'd0) begin
            state_d = S_BIT_H1;
          end else begin
            state_d = last_q ? S_FINISH : S_LOAD;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values and registered-output next values.
  always_comb begin
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    last_d     = last_q;
    level_d    = level_q;
    underrun_d = underrun_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          cnt_d      = HDR_RELOAD;
          hdr_d      = 16'd0;
          level_d    = 1'b0;
          underrun_d = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_HEADER, S_SYNC_A, S_SYNC_B, S_BIT_H1, S_BIT_H2: begin
        if (!expire_s) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          level_d = ~level_q;
          case (state_q)
            S_HEADER: begin
              if (hdr_q == HDR_LAST) begin
                cnt_d = SYNC_A_RELOAD;
              end else begin
                hdr_d = hdr_q + 16'd1;
                cnt_d = HDR_RELOAD;
              end
            end
            S_SYNC_A: cnt_d = SYNC_B_RELOAD;
            S_SYNC_B: cnt_d = 16'd0;
            S_BIT_H1: cnt_d = bit_half(shift_q[7]);
            S_BIT_H2: begin
              // Next bit is shift_q[6] since the shift happens on this same edge.
              shift_d = {shift_q[6:0], 1'b0};
              if (bitcnt_q != 3'd0) begin
                bitcnt_d = bitcnt_q - 3'd1;
                cnt_d    = bit_half(shift_q[6]);
              end else begin
                cnt_d = 16'd0;
              end
            end
            default: cnt_d = 16'd0;
          endcase
        end
      end
      S_LOAD: begin
        if (accept_s) begin
          shift_d  = byte_data;
          last_d   = byte_last;
          bitcnt_d = 3'd7;
          cnt_d    = bit_half(byte_data[7]);
        end else if (!byte_valid && !stop) begin
          underrun_d = 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_LOAD);
    done_d  = (state_d == S_FINISH);
    if (busy_d) begin
      tape_d = level_d;
    end else begin
      tape_d = idle_level_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q      <= 16'd0;
      hdr_q      <= 16'd0;
      shift_q    <= 8'd0;
      bitcnt_q   <= 3'd0;
      last_q     <= 1'b0;
      level_q    <= 1'b0;
      underrun_q <= 1'b0;
      tape_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      last_q     <= last_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
      tape_q     <= tape_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign byte_ready = ready_q;
  assign tape_in    = tape_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_tape_player.sv
// Directed bench for tape_player with short half-periods; waveform timing measured edge to edge on tape_in.
module tb_tape_player;

`ifdef TAPE_PLAYER_PASSTHRU_EN
  localparam bit PT = 1'b1;
`else
  localparam bit PT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       tape_in_ext;
  logic       tape_in;
  logic       busy;
  logic       done;
  logic       underrun;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  tape_player #(
    .HDR_HALF(10), .HDR_CYCLES(2), .SYNC_A_HALF(3),
    .SYNC_B_HALF(4), .ONE_HALF(6), .ZERO_HALF(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_last(byte_last),
    .byte_ready(byte_ready), .tape_in_ext(tape_in_ext), .tape_in(tape_in),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_toggle(output int n);
    logic prev;
    prev = tape_in;
    n = 0;
    do begin
      tick();
      n++;
    end while (tape_in === prev && n < 100);
  endtask

  task automatic expect_halves(input string tag, input int len, input int count);
    int n;
    for (int i = 0; i < count; i++) begin
      wait_toggle(n);
      chk(tag, n, len);
    end
  endtask

  task automatic bit_halves(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      expect_halves("bit_half", b[i] ? 6 : 3, 2);
    end
  endtask

  task automatic run_to_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_tape", tape_in, 0);
    expect_halves("hdr_half", 10, 4);
    expect_halves("sync_a", 3, 1);
    expect_halves("sync_b", 4, 1);
    chk("load_ready", byte_ready, 1);
  endtask

  initial begin
    int d0;
    int changes;
    logic lvl;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0;
    byte_data = 8'h00; byte_valid = 1'b0; byte_last = 1'b0; tape_in_ext = 1'b0;

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_tape", tape_in, 0);
    reset_n = 1'b1;
    tick();

    // Single byte 0xA5, last, valid held high.
    d0 = done_cnt;
    byte_data = 8'hA5; byte_last = 1'b1; byte_valid = 1'b1;
    run_to_load();
    tick();
    chk("a5_accept_ready", byte_ready, 0);
    bit_halves(8'hA5);
    chk("a5_done", done, 1);
    chk("a5_busy_finish", busy, 1);
    tick();
    chk("a5_done_low", done, 0);
    chk("a5_busy_low", busy, 0);
    chk("a5_tape_idle", tape_in, 0);
    chk("a5_done_count", done_cnt, d0 + 1);
    chk("a5_no_underrun", underrun, 0);
    byte_valid = 1'b0;
    tick();

    // Two bytes back to back: 0x00 then 0xFF (last).
    d0 = done_cnt;
    byte_data = 8'h00; byte_last = 1'b0; byte_valid = 1'b1;
    run_to_load();
    tick();
    byte_data = 8'hFF; byte_last = 1'b1;
    chk("b2_accept0_ready", byte_ready, 0);
    bit_halves(8'h00);
    chk("b2_gap_ready", byte_ready, 1);
    chk("b2_gap_busy", busy, 1);
    tick();
    chk("b2_accept1_ready", byte_ready, 0);
    bit_halves(8'hFF);
    chk("b2_done", done, 1);
    tick();
    chk("b2_busy_low", busy, 0);
    chk("b2_done_count", done_cnt, d0 + 1);
    byte_valid = 1'b0;
    tick();

    // Underrun: starve LOAD for 20 cycles then resume with 0x80.
    d0 = done_cnt;
    run_to_load();
    lvl = tape_in;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tape_in !== lvl) changes++;
    end
    chk("ur_tape_const", changes, 0);
    chk("ur_flag", underrun, 1);
    chk("ur_busy", busy, 1);
    chk("ur_ready", byte_ready, 1);
    byte_data = 8'h80; byte_last = 1'b1; byte_valid = 1'b1;
    tick();
    chk("ur_accept_ready", byte_ready, 0);
    bit_halves(8'h80);
    chk("ur_done", done, 1);
    tick();
    chk("ur_busy_low", busy, 0);
    chk("ur_flag_sticky", underrun, 1);
    chk("ur_done_count", done_cnt, d0 + 1);
    byte_valid = 1'b0;
    tick();

    // Abort during HEADER; start clears underrun.
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ab_busy", busy, 1);
    chk("ab_underrun_clr", underrun, 0);
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("ab_busy_low", busy, 0);
    chk("ab_ready_low", byte_ready, 0);
    chk("ab_tape", tape_in, 0);
    repeat (5) tick();
    chk("ab_no_done", done_cnt, d0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    tick();
    chk("ss_busy2", busy, 0);

    // Stop in LOAD preserves underrun; reset clears it.
    run_to_load();
    repeat (3) tick();
    chk("sp_underrun", underrun, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sp_busy", busy, 0);
    chk("sp_ready", byte_ready, 0);
    chk("sp_underrun_kept", underrun, 1);
    chk("sp_no_done", done_cnt, d0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rs_underrun_clr", underrun, 0);

    // Reset mid-playback.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("rm_busy_before", busy, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rm_busy", busy, 0);
    chk("rm_tape", tape_in, 0);
    tick();

    // Idle pass-through (or held low) and ignore while busy.
    tape_in_ext = 1'b1;
    chk("pt_delay", tape_in, 0);
    tick();
    chk("pt_follow1", tape_in, PT ? 1 : 0);
    tape_in_ext = 1'b0;
    tick();
    chk("pt_follow0", tape_in, 0);
    tape_in_ext = 1'b1;
    tick();
    chk("pt_follow1b", tape_in, PT ? 1 : 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tape_in_ext = ~tape_in_ext;
      tick();
      chk("pt_busy_ignore", tape_in, 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("pt_after_stop", tape_in, PT ? tape_in_ext : 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
